// File: rtl/rf_stream_reader.sv
// Sweeps a contiguous register-file address range, one read per cycle, and streams the
// returned words downstream on a valid/ready interface tagged with address and last flag.
module rf_stream_reader #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   count,
    output logic                 busy,
    output logic                 done,
    input  logic                 rf_we,
    output logic [ADDR_BITS-1:0] rf_raddr,
    input  logic [DATA_BITS-1:0] rf_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic                 out_last
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [ADDR_BITS:0] ONE = 1;

    state_t state, state_nxt;

    logic [ADDR_BITS-1:0] base_r;
    logic [ADDR_BITS:0]   count_r;
    logic [ADDR_BITS:0]   issued;

    logic                 inflight;
    logic                 inflight_last;
    logic [ADDR_BITS-1:0] inflight_addr;

    logic [DATA_BITS-1:0] fifo_data [2];
    logic [ADDR_BITS-1:0] fifo_addr [2];
    logic                 fifo_last [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           fifo_count;

    logic       push;
    logic       pop;
    logic       issue;
    logic       last_issue;
    logic       done_set;
    logic [2:0] occupancy;

    assign busy      = (state != IDLE);
    assign rf_raddr  = base_r + issued[ADDR_BITS-1:0];
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_addr  = fifo_addr[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // Entries the FIFO will hold after this edge; a new issue lands one edge later,
    // so it is only safe while that figure leaves a free slot.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    // rf_we makes the RF return write data instead of rf[raddr], so no read is issued then.
    assign issue      = (state == RUN) && (issued != count_r) && !rf_we && (occupancy < 3'd2);
    assign last_issue = issue && ((issued + ONE) == count_r);

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_nxt = RUN;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            done          <= 1'b0;
            base_r        <= '0;
            count_r       <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_addr <= '0;
        end else begin
            state         <= state_nxt;
            done          <= done_set;
            inflight      <= issue;
            inflight_last <= last_issue;
            inflight_addr <= rf_raddr;
            if (state == IDLE && start) begin
                base_r  <= base_addr;
                count_r <= count;
                issued  <= '0;
            end else if (issue) begin
                issued <= issued + ONE;
            end
        end
    end

    // Two-entry output FIFO; the registered read data is captured the edge after issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rf_q;
                fifo_addr[wr_ptr] <= inflight_addr;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_rf_stream_reader.sv
// Directed bench for rf_stream_reader: a small RF model with write bypass on the read port,
// a per-cycle sweep driver, and one task per scenario comparing against hand-derived values.
module tb_rf_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  base_addr;
    logic [7:0]  count;
    logic        busy;
    logic        done;
    logic        rf_we;
    logic [6:0]  rf_raddr;
    logic [12:0] rf_q;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic [6:0]  out_addr;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    localparam logic [12:0] WR_DATA = 13'h1ABC;

    int q_data[$];
    int q_addr[$];
    int q_last[$];
    int q_cyc[$];
    int done_cyc;
    int done_pulses;
    int busy_low_cyc;
    int busy_seen;
    int stall_err;

    rf_stream_reader #(.ADDR_BITS(7), .DATA_BITS(13)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rf_we     (rf_we),
        .rf_raddr  (rf_raddr),
        .rf_q      (rf_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // RF model: rf[a] = a*3; a write cycle returns the written word instead of rf[raddr].
    always @(posedge clk) begin
        rf_q <= rf_we ? WR_DATA : 13'(rf_raddr) * 13'd3;
    end

    // Drives one sweep starting at cycle 0 (called at posedge+1) and records accepted words.
    task automatic run_sweep(input logic [6:0] b, input logic [7:0] c, input int ready_mode,
                             input int we_lo, input int we_hi, input int s2_cyc,
                             input logic [6:0] b2, input logic [7:0] c2, input int limit);
        logic        stalled;
        logic [12:0] held_data;
        logic [6:0]  held_addr;
        q_data.delete(); q_addr.delete(); q_last.delete(); q_cyc.delete();
        done_cyc = -1; done_pulses = 0; busy_low_cyc = -1; busy_seen = 0; stall_err = 0;
        stalled = 1'b0; held_data = '0; held_addr = '0;
        for (int cyc = 0; cyc < limit; cyc++) begin
            start     = (cyc == 0) || (cyc == s2_cyc);
            base_addr = (cyc == s2_cyc) ? b2 : b;
            count     = (cyc == s2_cyc) ? c2 : c;
            out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            rf_we     = (cyc >= we_lo) && (cyc <= we_hi);
            @(negedge clk);
            if (stalled && (!out_valid || out_data !== held_data || out_addr !== held_addr))
                stall_err++;
            if (out_valid && out_ready) begin
                q_data.push_back(int'(out_data));
                q_addr.push_back(int'(out_addr));
                q_last.push_back(int'(out_last));
                q_cyc.push_back(cyc);
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_addr = out_addr;
            if (busy) busy_seen++;
            else if (busy_seen > 0 && busy_low_cyc < 0) busy_low_cyc = cyc;
            if (done === 1'b1) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0; rf_we = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; rf_we = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
        checks++; if (rf_raddr !== 7'd0) begin errors++; $display("FAIL reset_raddr: got %0d expected 0", rf_raddr); end
        checks++; if (out_data !== 13'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        checks++; if (out_addr !== 7'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", out_addr); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        run_sweep(7'd5, 8'd4, 0, -1, -1, -1, 7'd0, 8'd0, 40);
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL basic_words: got %0d expected 4", q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 4; k++) begin
            checks++; if (q_data[k] != (5 + k) * 3) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", k, q_data[k], (5 + k) * 3); end
            checks++; if (q_addr[k] != 5 + k) begin errors++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", k, q_addr[k], 5 + k); end
            checks++; if (q_last[k] != ((k == 3) ? 1 : 0)) begin errors++; $display("FAIL basic_last[%0d]: got %0d expected %0d", k, q_last[k], (k == 3) ? 1 : 0); end
            checks++; if (q_cyc[k] != 3 + k) begin errors++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", k, q_cyc[k], 3 + k); end
        end
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_pulses); end
        checks++; if (busy_low_cyc != 7) begin errors++; $display("FAIL basic_busy_low: got %0d expected 7", busy_low_cyc); end
    endtask

    task automatic test_backpressure;
        run_sweep(7'd5, 8'd4, 1, -1, -1, -1, 7'd0, 8'd0, 60);
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL bp_words: got %0d expected 4", q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 4; k++) begin
            checks++; if (q_data[k] != (5 + k) * 3) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", k, q_data[k], (5 + k) * 3); end
            checks++; if (q_addr[k] != 5 + k) begin errors++; $display("FAIL bp_addr[%0d]: got %0d expected %0d", k, q_addr[k], 5 + k); end
            checks++; if (q_last[k] != ((k == 3) ? 1 : 0)) begin errors++; $display("FAIL bp_last[%0d]: got %0d expected %0d", k, q_last[k], (k == 3) ? 1 : 0); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_head_stable: got %0d unstable cycles expected 0", stall_err); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL bp_done_pulses: got %0d expected 1", done_pulses); end
    endtask

    task automatic test_write_interference;
        run_sweep(7'd0, 8'd3, 0, 1, 3, -1, 7'd0, 8'd0, 40);
        checks++; if (q_data.size() != 3) begin errors++; $display("FAIL we_words: got %0d expected 3", q_data.size()); end
        for (int k = 0; k < q_data.size() && k < 3; k++) begin
            checks++; if (q_data[k] != k * 3) begin errors++; $display("FAIL we_data[%0d]: got %0d expected %0d", k, q_data[k], k * 3); end
            checks++; if (q_addr[k] != k) begin errors++; $display("FAIL we_addr[%0d]: got %0d expected %0d", k, q_addr[k], k); end
        end
        if (q_cyc.size() > 0) begin
            checks++; if (q_cyc[0] != 6) begin errors++; $display("FAIL we_first_valid: got %0d expected 6", q_cyc[0]); end
        end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL we_done_cycle: got %0d expected 9", done_cyc); end
    endtask

    task automatic test_wrap;
        run_sweep(7'h7E, 8'd4, 0, -1, -1, -1, 7'd0, 8'd0, 40);
        checks++; if (q_addr.size() != 4) begin errors++; $display("FAIL wrap_words: got %0d expected 4", q_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < 4; k++) begin
            checks++; if (q_addr[k] != ((126 + k) % 128)) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, q_addr[k], (126 + k) % 128); end
            checks++; if (q_data[k] != ((126 + k) % 128) * 3) begin errors++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", k, q_data[k], ((126 + k) % 128) * 3); end
        end
        checks++; if (q_last.size() == 4 && q_last[3] != 1) begin errors++; $display("FAIL wrap_last: got %0d expected 1", q_last[3]); end
    endtask

    task automatic test_count_zero;
        run_sweep(7'h33, 8'd0, 0, -1, -1, -1, 7'd0, 8'd0, 20);
        checks++; if (q_data.size() != 0) begin errors++; $display("FAIL zero_words: got %0d expected 0", q_data.size()); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", done_pulses); end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_seen); end
    endtask

    task automatic test_full_range;
        int bad_data;
        int lasts;
        run_sweep(7'd0, 8'd128, 0, -1, -1, -1, 7'd0, 8'd0, 200);
        bad_data = 0; lasts = 0;
        checks++; if (q_data.size() != 128) begin errors++; $display("FAIL full_words: got %0d expected 128", q_data.size()); end
        for (int k = 0; k < q_data.size(); k++) begin
            if (q_addr[k] != k || q_data[k] != k * 3) bad_data++;
            lasts += q_last[k];
        end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL full_sequence: got %0d wrong words expected 0", bad_data); end
        checks++; if (lasts != 1) begin errors++; $display("FAIL full_last_count: got %0d expected 1", lasts); end
        if (q_last.size() == 128) begin
            checks++; if (q_last[127] != 1) begin errors++; $display("FAIL full_last_pos: got %0d expected 1", q_last[127]); end
        end
        checks++; if (done_cyc != 131) begin errors++; $display("FAIL full_done_cycle: got %0d expected 131", done_cyc); end
    endtask

    task automatic test_start_while_busy;
        run_sweep(7'd40, 8'd6, 0, -1, -1, 2, 7'd90, 8'd3, 40);
        checks++; if (q_addr.size() != 6) begin errors++; $display("FAIL busy_start_words: got %0d expected 6", q_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < 6; k++) begin
            checks++; if (q_addr[k] != 40 + k) begin errors++; $display("FAIL busy_start_addr[%0d]: got %0d expected %0d", k, q_addr[k], 40 + k); end
        end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 9", done_cyc); end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL busy_start_done_pulses: got %0d expected 1", done_pulses); end
    endtask

    task automatic test_reset_mid_sweep;
        int accepted;
        accepted = 0;
        start = 1'b1; base_addr = 7'd10; count = 8'd8; out_ready = 1'b1; rf_we = 1'b0;
        for (int cyc = 0; cyc < 20 && accepted < 2; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) accepted++;
            if (accepted < 2) begin
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (accepted != 2) begin errors++; $display("FAIL rst_mid_pre_words: got %0d expected 2", accepted); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 13'd0) begin errors++; $display("FAIL rst_mid_data: got %0d expected 0", out_data); end
        checks++; if (out_addr !== 7'd0) begin errors++; $display("FAIL rst_mid_addr: got %0d expected 0", out_addr); end
        checks++; if (rf_raddr !== 7'd0) begin errors++; $display("FAIL rst_mid_raddr: got %0d expected 0", rf_raddr); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        run_sweep(7'd20, 8'd5, 0, -1, -1, -1, 7'd0, 8'd0, 40);
        checks++; if (q_addr.size() != 5) begin errors++; $display("FAIL rst_mid_words: got %0d expected 5", q_addr.size()); end
        for (int k = 0; k < q_addr.size() && k < 5; k++) begin
            checks++; if (q_addr[k] != 20 + k || q_data[k] != (20 + k) * 3) begin errors++; $display("FAIL rst_mid_word[%0d]: got addr %0d data %0d expected addr %0d data %0d", k, q_addr[k], q_data[k], 20 + k, (20 + k) * 3); end
        end
        checks++; if (done_cyc != 8) begin errors++; $display("FAIL rst_mid_done_cycle: got %0d expected 8", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_write_interference();
        test_wrap();
        test_count_zero();
        test_full_range();
        test_start_while_busy();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
